// File: rtl/button_bouncer.sv
// Purpose : synthetic contact-bounce generator; a clean level in, switch-like chatter out.
// Latency : 1 cycle pass-through when disabled; BOUNCE_CYCLES cycles of chatter per level change when enabled.
// Backpressure: none; free-running stream, level_in is sampled every cycle and never stalled.
//
// Ports
//   clk            clock, all state changes on posedge
//   reset          synchronous, active-high; wins over everything, may land mid-burst
//   enable         1 = generate bounce, 0 = registered pass-through of level_in
//   level_in       clean level to emulate, synchronous to clk
//   bounce_out     registered bouncy copy of level_in
//   busy           registered, high for every cycle a chatter window is in progress
//   chatter_count  bounce_out toggles seen inside chatter windows since reset, saturating at 255
//
// Parameters
//   BOUNCE_CYCLES  chatter window length in clk cycles, legal 1..255
//   SEED           LFSR reset value; zero is mapped to 8'h01 so the LFSR never locks up

module button_bouncer #(
    parameter int unsigned BOUNCE_CYCLES = 32,
    parameter logic [7:0]  SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       level_in,
    output logic       bounce_out,
    output logic       busy,
    output logic [7:0] chatter_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    // An all-zero LFSR would stay at zero forever, so a zero seed becomes 1.
    localparam logic [7:0] LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;

    // The entry cycle itself is the first chatter cycle, so the counter is
    // loaded with one less than the window length and the window ends on the
    // cycle that observes cnt == 0.
    localparam logic [7:0] CNT_LOAD = 8'(BOUNCE_CYCLES - 1);

    state_t     state;
    logic       target;     // last accepted level
    logic [7:0] cnt;        // cycles of chatter left after the current one
    logic [7:0] lfsr;

    logic       lfsr_fb;
    logic       level_change;
    logic       nxt_bounce;
    logic       chatter_inc;

    // Taps 8,6,5,4: maximal length, period 255.
    assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign level_change = (level_in != target);

    // Next value of bounce_out. Kept separate from the FSM because the
    // chatter counter needs to compare it against the current output.
    // Priority inside a window: disable, then reversal, then window end.
    always_comb begin
        nxt_bounce = bounce_out;
        if (!enable) begin
            nxt_bounce = level_in;
        end else if (level_change) begin
            nxt_bounce = lfsr[0];
        end else if (state == BOUNCE) begin
            nxt_bounce = (cnt == 8'd0) ? target : lfsr[0];
        end else begin
            nxt_bounce = target;
        end
    end

    // Every toggle of bounce_out decided while in BOUNCE counts, including the
    // settling edge and an abort edge; the entry edge (decided in IDLE) does not.
    assign chatter_inc = (state == BOUNCE) && (nxt_bounce != bounce_out) &&
                         (chatter_count != 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            target        <= 1'b0;
            cnt           <= 8'd0;
            lfsr          <= LFSR_INIT;
            bounce_out    <= 1'b0;
            busy          <= 1'b0;
            chatter_count <= 8'd0;
        end else begin
            // The LFSR runs regardless of state so the chatter pattern depends
            // only on the time since reset, which keeps runs repeatable.
            lfsr       <= {lfsr[6:0], lfsr_fb};
            bounce_out <= nxt_bounce;
            if (chatter_inc) begin
                chatter_count <= chatter_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (!enable) begin
                        target <= level_in;
                        busy   <= 1'b0;
                    end else if (level_change) begin
                        target <= level_in;
                        cnt    <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= BOUNCE;
                    end
                end

                BOUNCE: begin
                    if (!enable) begin
                        // Abort: follow the input directly from the next cycle.
                        target <= level_in;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (level_change) begin
                        // Reversal mid-burst restarts a full window; busy stays high.
                        target <= level_in;
                        cnt    <= CNT_LOAD;
                    end else if (cnt == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_bouncer.sv
// Purpose : bench for button_bouncer; three instances (8/A5, 32/A5, 1/00) share stimulus.
// Latency : outputs are sampled 1 ns after each rising edge and compared to a deadline-based model.
// Backpressure: none; the bench drives a free-running input stream.
`timescale 1ns/1ps

module tb_button_bouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, level_in;
    logic bo_a, busy_a, bo_b, busy_b, bo_c, busy_c;
    logic [7:0] cc_a, cc_b, cc_c;

    button_bouncer #(.BOUNCE_CYCLES(8), .SEED(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .level_in(level_in),
        .bounce_out(bo_a), .busy(busy_a), .chatter_count(cc_a));

    button_bouncer #(.BOUNCE_CYCLES(32), .SEED(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .level_in(level_in),
        .bounce_out(bo_b), .busy(busy_b), .chatter_count(cc_b));

    button_bouncer #(.BOUNCE_CYCLES(1), .SEED(8'h00)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .level_in(level_in),
        .bounce_out(bo_c), .busy(busy_c), .chatter_count(cc_c));

    int vectors = 0;
    int misc    = 0;

    // Reference model: a window is an absolute deadline in cycles since reset,
    // and the chatter bit is the LFSR value looked up by that cycle count.
    typedef struct {
        bit target;
        bit bounce;
        bit busy;
        int cnt;
        int cyc;
        int win_end;
    } model_t;

    model_t     m[3];
    int         bc[3] = '{8, 32, 1};
    logic [7:0] seq[3][255];

    // Loopback debouncer fed by instance b.
    logic [7:0] hist = 8'h00;
    logic       deb = 1'b0;
    logic       last_b = 1'b0;
    int         deb_edges = 0;

    typedef struct {
        bit r, e, l;
        bit chk_bo, exp_bo, exp_busy;
        bit chk_cc;
        int exp_cc;
    } vec_t;

    vec_t tbl[13];

    task automatic build_seq(input int idx, input logic [7:0] seed);
        logic [7:0] s;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < 255; k++) begin
            seq[idx][k] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    endtask

    function automatic model_t step(model_t s, int i, bit r, bit e, bit l);
        model_t n;
        logic [7:0] word;
        bit chat, nb;
        n = s;
        if (r) begin
            n.target = 0; n.bounce = 0; n.busy = 0;
            n.cnt = 0; n.cyc = 0; n.win_end = 0;
            return n;
        end
        word = seq[i][s.cyc % 255];
        chat = word[0];
        if (!e) begin
            nb = l; n.target = l; n.busy = 0;
        end else if (l != s.target) begin
            nb = chat; n.target = l; n.busy = 1; n.win_end = s.cyc + bc[i];
        end else if (s.busy && s.cyc >= s.win_end) begin
            nb = s.target; n.busy = 0;
        end else if (s.busy) begin
            nb = chat;
        end else begin
            nb = s.target;
        end
        if (s.busy && nb != s.bounce && s.cnt < 255) n.cnt = s.cnt + 1;
        n.bounce = nb;
        n.cyc    = s.cyc + 1;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step(m[i], i, reset, enable, level_in);
        hist = {hist[6:0], last_b};
        if (reset) begin
            hist = 8'h00;
            deb  = 1'b0;
        end else if (hist == 8'hFF && !deb) begin
            deb = 1'b1; deb_edges++;
        end else if (hist == 8'h00 && deb) begin
            deb = 1'b0; deb_edges++;
        end
        #1;
        check("model bounce_a", bo_a, m[0].bounce);
        check("model busy_a", busy_a, m[0].busy);
        check("model count_a", cc_a, m[0].cnt);
        check("model bounce_b", bo_b, m[1].bounce);
        check("model busy_b", busy_b, m[1].busy);
        check("model count_b", cc_b, m[1].cnt);
        check("model bounce_c", bo_c, m[2].bounce);
        check("model busy_c", busy_c, m[2].busy);
        check("model count_c", cc_c, m[2].cnt);
        last_b = bo_b;
    endtask

    task automatic settle(input bit e, input bit l, input int n);
        enable   = e;
        level_in = l;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int n_a, n_b, n_c, runs, k;
        bit prev;

        reset = 1'b1; enable = 1'b1; level_in = 1'b1;
        build_seq(0, 8'hA5);
        build_seq(1, 8'hA5);
        build_seq(2, 8'h00);
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0};

        // r e l chk_bo exp_bo exp_busy chk_cc exp_cc
        tbl[0]  = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[1]  = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 1, 1, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 1, 1, 0};   // burst starts right after reset
        tbl[4]  = '{0, 0, 1, 1, 1, 0, 0, 0};   // abort: follow level_in
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 0, 0, 0};   // enabled, no change: hold
        tbl[10] = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 1, 1, 0, 0, 0};   // target already 1: no burst

        for (int v = 0; v < 13; v++) begin
            reset = tbl[v].r; enable = tbl[v].e; level_in = tbl[v].l;
            tick();
            if (tbl[v].chk_bo) begin
                check("tbl bounce_a", bo_a, tbl[v].exp_bo);
                check("tbl bounce_b", bo_b, tbl[v].exp_bo);
                check("tbl bounce_c", bo_c, tbl[v].exp_bo);
            end
            check("tbl busy_a", busy_a, tbl[v].exp_busy);
            check("tbl busy_b", busy_b, tbl[v].exp_busy);
            check("tbl busy_c", busy_c, tbl[v].exp_busy);
            if (tbl[v].chk_cc) begin
                check("tbl count_a", cc_a, tbl[v].exp_cc);
                check("tbl count_c", cc_c, tbl[v].exp_cc);
            end
        end

        // Single burst: busy length per instance, then settled high.
        settle(0, 0, 3);
        settle(1, 0, 3);
        level_in = 1'b1;
        n_a = 0; n_b = 0; n_c = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            n_a += busy_a; n_b += busy_b; n_c += busy_c;
        end
        check("burst busy_len_a", n_a, 8);
        check("burst busy_len_b", n_b, 20);
        check("burst busy_len_c", n_c, 1);
        check("burst settled_a", bo_a, 1);
        check("burst settled_c", bo_c, 1);

        // Reversal four cycles into an 8-cycle window.
        settle(1, 0, 40);
        level_in = 1'b1;
        n_a = 0; runs = 0; prev = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (j == 4) level_in = 1'b0;
            tick();
            if (busy_a && !prev) runs++;
            n_a += busy_a;
            prev = busy_a;
        end
        check("reversal busy_len_a", n_a, 12);
        check("reversal busy_runs_a", runs, 1);
        check("reversal settled_a", bo_a, 0);

        // Abort by dropping enable on the fourth cycle of a burst.
        settle(1, 0, 40);
        level_in = 1'b1;
        tick(); tick(); tick();
        check("abort busy_before_a", busy_a, 1);
        enable = 1'b0;
        tick();
        check("abort bounce_a", bo_a, 1);
        check("abort busy_a", busy_a, 0);
        check("abort bounce_b", bo_b, 1);
        check("abort busy_b", busy_b, 0);

        // Reset at the same point of a burst.
        settle(1, 0, 40);
        level_in = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("rst bounce_a", bo_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst count_a", cc_a, 0);
        check("rst bounce_b", bo_b, 0);
        check("rst count_b", cc_b, 0);
        reset = 1'b0;
        tick();
        // Fresh LFSR: the first chatter bit is bit 0 of the seed (A5 and 01).
        check("rst first_bit_a", bo_a, 1);
        check("rst first_bit_c", bo_c, 1);
        check("rst busy_after_a", busy_a, 1);
        settle(1, 1, 40);

        // Loopback through an 8-sample debouncer on the 32-cycle instance.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle(1, 0, 50);
        deb_edges = 0;
        for (int t = 0; t < 20; t++) begin
            level_in = ~level_in;
            k = 0;
            while (deb != level_in && k < 45) begin
                tick();
                k++;
            end
            check("loop latency_ok", (k <= 41), 1);
            for (int j = k; j < 100; j++) tick();
        end
        check("loop deb_edges", deb_edges, 20);

        // Random traffic: rare resets, occasional disable, frequent level changes.
        for (int j = 0; j < 3000; j++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) level_in = ~level_in;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
